// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared state encoding, frame width and baud divider helper for the UART blocks.
package uart_rx_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT} uart_rx_state_t;
  localparam int DATA_BITS = 8;
  function automatic int baud_div(input int clk_hz, input int baud, input int ovs);
    return clk_hz / (baud * ovs);
  endfunction
endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: received-byte bus between the UART receiver and its consumer.
interface uart_rx_if;
  import uart_rx_pkg::*;
  logic [DATA_BITS-1:0] rx_data;
  logic rx_ready, rx_load, frame_err, overrun;
  modport master(output rx_data, rx_ready, frame_err, overrun, input rx_load);
  modport slave(input rx_data, rx_ready, frame_err, overrun, output rx_load);
endinterface

// File: rtl/uart_rx_baud_tick.sv
// uart_baud_tick: free-running divider emitting a 1-clk tick every DIV clocks, restartable.
module uart_baud_tick #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic nrst,
  input  logic i_restart,
  output logic o_tick
);
  localparam int W = DIV > 1 ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);
  logic [W-1:0] r_cnt;
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) r_cnt <= '0;
    else r_cnt <= (i_restart || o_tick) ? '0 : r_cnt + 1'b1;
  assign o_tick = r_cnt == LAST;
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 LSB-first oversampling UART receiver presenting bytes on a ready/load bus.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic      clk,
  input  logic      nrst,
  input  logic      rx,
  uart_rx_if.master bus
);
  localparam int DIV = baud_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int SW = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0] HALF = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] LASTS = SW'(OVERSAMPLE - 1);
  if (DIV < 1) begin : g_div_chk
    $error("uart_rx: clock too slow for BAUD*OVERSAMPLE");
  end
  if (OVERSAMPLE < 4 || OVERSAMPLE % 2 != 0) begin : g_ovs_chk
    $error("uart_rx: OVERSAMPLE must be even and >= 4");
  end
  uart_rx_state_t r_state, w_next;
  logic [1:0] r_sync;
  logic [SW-1:0] r_scnt;
  logic [2:0] r_bcnt;
  logic [DATA_BITS-1:0] r_shift, r_data;
  logic r_ready, r_ferr, r_ovr;
  logic w_rxs, w_tick, w_restart, w_clr_scnt, w_shift, w_deliver, w_ferr, w_load;
  assign w_rxs  = r_sync[1];
  assign w_load = bus.rx_load;
  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk      (clk),
    .nrst     (nrst),
    .i_restart(w_restart),
    .o_tick   (w_tick)
  );
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next     = r_state;
    w_restart  = 1'b0;
    w_clr_scnt = 1'b0;
    w_shift    = 1'b0;
    w_deliver  = 1'b0;
    w_ferr     = 1'b0;
    case (r_state)
      IDLE: if (!w_rxs) begin
        w_next     = START;
        w_restart  = 1'b1;
        w_clr_scnt = 1'b1;
      end
      START: if (w_tick && r_scnt == HALF) begin
        w_next     = w_rxs ? IDLE : DATA;
        w_clr_scnt = 1'b1;
      end
      DATA: if (w_tick && r_scnt == LASTS) begin
        w_shift    = 1'b1;
        w_clr_scnt = 1'b1;
        w_next     = r_bcnt == 3'(DATA_BITS - 1) ? STOP : DATA;
      end
      STOP: if (w_tick && r_scnt == LASTS) begin
        w_next     = w_rxs ? IDLE : WAIT;
        w_deliver  = w_rxs;
        w_ferr     = !w_rxs;
        w_clr_scnt = 1'b1;
      end
      WAIT: w_next = w_rxs ? IDLE : WAIT;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      r_sync  <= 2'b11;
      r_scnt  <= '0;
      r_bcnt  <= '0;
      r_shift <= '0;
    end else begin
      r_sync  <= {r_sync[0], rx};
      r_scnt  <= w_clr_scnt ? '0 : w_tick ? r_scnt + 1'b1 : r_scnt;
      r_bcnt  <= r_state == START ? '0 : w_shift ? r_bcnt + 1'b1 : r_bcnt;
      r_shift <= w_shift ? {w_rxs, r_shift[DATA_BITS-1:1]} : r_shift;
    end
  // A delivery coinciding with rx_load wins: ready stays set and no overrun is raised.
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      r_data  <= '0;
      r_ready <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_data  <= w_deliver ? r_shift : r_data;
      r_ready <= w_deliver || (r_ready && !w_load);
      r_ferr  <= w_ferr || (r_ferr && !w_load);
      r_ovr   <= !w_load && (r_ovr || (w_deliver && r_ready));
    end
  assign bus.rx_data   = r_data;
  assign bus.rx_ready  = r_ready;
  assign bus.frame_err = r_ferr;
  assign bus.overrun   = r_ovr;
endmodule
